// File: rtl/image_pkg.sv
// Shared definitions for the image readout controller: FSM state encoding
// and width helpers used to size counters from parameters.
package image_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VBLANK = 3'd1,
        HBLANK = 3'd2,
        DATA   = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Bit width able to hold 0..value-1, never narrower than one bit.
    function automatic int width_of(input int value);
        return (value < 2) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/image_delay_cnt.sv
// Loadable down-counter with a zero flag, shared by vertical and horizontal
// blanking intervals of the readout controller.
module image_delay_cnt
    import image_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Clear beats load beats decrement; the count saturates at zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/image_read_ctrl.sv
// Frame readout controller: generates blanking strobes and a linear pixel
// address stream, one line at a time, with rd_ready back-pressure.
module image_read_ctrl
    import image_pkg::*;
#(
    parameter int WIDTH       = 768,
    parameter int HEIGHT      = 512,
    parameter int VSYNC_DELAY = 100,
    parameter int HSYNC_DELAY = 160
) (
    input  logic                                HCLK,
    input  logic                                HRESET,
    input  logic                                start,
    input  logic                                abort,
    input  logic                                rd_ready,
    output logic                                VSYNC,
    output logic                                HSYNC,
    output logic                                rd_en,
    output logic [clog2(WIDTH*HEIGHT)-1:0]      rd_addr,
    output logic                                busy,
    output logic                                ctrl_done
);

    localparam int ADDR_W  = clog2(WIDTH*HEIGHT);
    localparam int COL_W   = width_of(WIDTH);
    localparam int ROW_W   = width_of(HEIGHT);
    localparam int DLY_MAX = (VSYNC_DELAY > HSYNC_DELAY) ? VSYNC_DELAY : HSYNC_DELAY;
    localparam int CNT_W   = width_of(DLY_MAX);

    // The counter holds remaining blanking cycles minus one, so zero marks the last cycle.
    localparam logic [CNT_W-1:0] VLOAD    = CNT_W'(VSYNC_DELAY - 1);
    localparam logic [CNT_W-1:0] HLOAD    = CNT_W'(HSYNC_DELAY - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    state_t              r_state;
    logic [ROW_W-1:0]    r_row;
    logic [COL_W-1:0]    r_col;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_vsync;
    logic                r_hsync;
    logic                r_rd_en;
    logic                r_busy;
    logic                r_done;

    logic                w_zero;
    logic                w_clr;
    logic                w_load;
    logic [CNT_W-1:0]    w_load_val;
    logic                w_dec;
    logic                w_abort;
    logic                w_line_end;

    assign w_abort    = abort && (r_state != IDLE);
    assign w_line_end = r_rd_en && rd_ready && (r_col == COL_LAST);

    always_comb begin
        w_clr      = 1'b0;
        w_load     = 1'b0;
        w_load_val = '0;
        w_dec      = 1'b0;
        if (w_abort) begin
            w_clr = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_load     = 1'b1;
                        w_load_val = VLOAD;
                    end
                end
                VBLANK: begin
                    if (w_zero) begin
                        w_load     = 1'b1;
                        w_load_val = HLOAD;
                    end else begin
                        w_dec = 1'b1;
                    end
                end
                HBLANK: begin
                    w_dec = !w_zero;
                end
                DATA: begin
                    if (w_line_end && (r_row != ROW_LAST)) begin
                        w_load     = 1'b1;
                        w_load_val = HLOAD;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    image_delay_cnt #(
        .CNT_W (CNT_W)
    ) u_delay_cnt (
        .i_clk      (HCLK),
        .i_rst      (HRESET),
        .i_clr      (w_clr),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    // r_ptr is the next address to issue; r_rd_addr only moves while in DATA.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state   <= IDLE;
            r_row     <= '0;
            r_col     <= '0;
            r_ptr     <= '0;
            r_rd_addr <= '0;
            r_vsync   <= 1'b0;
            r_hsync   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (w_abort) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_ptr   <= '0;
            r_vsync <= 1'b0;
            r_hsync <= 1'b0;
            r_rd_en <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= VBLANK;
                        r_vsync <= 1'b1;
                        r_busy  <= 1'b1;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_ptr   <= '0;
                    end
                end
                VBLANK: begin
                    if (w_zero) begin
                        r_state <= HBLANK;
                        r_vsync <= 1'b0;
                        r_row   <= '0;
                    end
                end
                HBLANK: begin
                    if (w_zero) begin
                        r_state   <= DATA;
                        r_col     <= '0;
                        r_hsync   <= 1'b1;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= r_ptr;
                    end
                end
                DATA: begin
                    if (rd_ready) begin
                        r_ptr <= r_ptr + 1'b1;
                        if (r_col == COL_LAST) begin
                            r_col   <= '0;
                            r_hsync <= 1'b0;
                            r_rd_en <= 1'b0;
                            if (r_row != ROW_LAST) begin
                                r_state <= HBLANK;
                                r_row   <= r_row + 1'b1;
                            end else begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_col     <= r_col + 1'b1;
                            r_rd_addr <= r_ptr + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_row   <= '0;
                    r_ptr   <= '0;
                end
                default: begin
                    r_state <= IDLE;
                    r_row   <= '0;
                    r_col   <= '0;
                    r_ptr   <= '0;
                    r_vsync <= 1'b0;
                    r_hsync <= 1'b0;
                    r_rd_en <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign VSYNC     = r_vsync;
    assign HSYNC     = r_hsync;
    assign rd_en     = r_rd_en;
    assign rd_addr   = r_rd_addr;
    assign busy      = r_busy;
    assign ctrl_done = r_done;

endmodule

// File: tb/tb_image_read_ctrl.sv
// Self-checking bench for image_read_ctrl: directed frame scenarios plus
// randomized start/abort/rd_ready against a token-queue reference model.
module tb_image_read_ctrl;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int VD = 3;
    localparam int HD = 2;
    localparam int AW = 3;

    localparam int K_VBL = 1;
    localparam int K_HBL = 2;
    localparam int K_PIX = 3;
    localparam int K_END = 4;

    typedef struct {
        int kind;
        int addr;
    } token_t;

    logic          HCLK;
    logic          HRESET;
    logic          start;
    logic          abort;
    logic          rd_ready;
    logic          VSYNC;
    logic          HSYNC;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          busy;
    logic          ctrl_done;

    // The frame still to be produced, one token per visible cycle (pixels wait for rd_ready).
    token_t model[$];
    int     lastAddr;
    int     errors;
    int     checks;
    int     label;
    int     doneLabel;
    int     frameAccepts;

    image_read_ctrl #(
        .WIDTH       (W),
        .HEIGHT      (H),
        .VSYNC_DELAY (VD),
        .HSYNC_DELAY (HD)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .start     (start),
        .abort     (abort),
        .rd_ready  (rd_ready),
        .VSYNC     (VSYNC),
        .HSYNC     (HSYNC),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .busy      (busy),
        .ctrl_done (ctrl_done)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t, label=%0d)", tag, observed, expected, $time, label);
        end
    endtask

    task automatic pushToken(input int kind, input int addr);
        token_t t;
        t.kind = kind;
        t.addr = addr;
        model.push_back(t);
    endtask

    task automatic buildFrame();
        for (int v = 0; v < VD; v++) pushToken(K_VBL, 0);
        for (int row = 0; row < H; row++) begin
            for (int hb = 0; hb < HD; hb++) pushToken(K_HBL, 0);
            for (int col = 0; col < W; col++) pushToken(K_PIX, row * W + col);
        end
        pushToken(K_END, 0);
    endtask

    task automatic modelStep(input logic s, input logic a, input logic r);
        if (model.size() == 0) begin
            if (s) buildFrame();
        end else if (a) begin
            model.delete();
        end else if ((model[0].kind != K_PIX) || r) begin
            void'(model.pop_front());
        end
    endtask

    task automatic checkCycle();
        int k;
        int a;
        k = (model.size() > 0) ? model[0].kind : 0;
        a = (k == K_PIX) ? model[0].addr : lastAddr;
        if (k == K_PIX) lastAddr = a;
        checkOutput("VSYNC",     32'(VSYNC),     32'(k == K_VBL));
        checkOutput("HSYNC",     32'(HSYNC),     32'(k == K_PIX));
        checkOutput("rd_en",     32'(rd_en),     32'(k == K_PIX));
        checkOutput("rd_addr",   32'(rd_addr),   32'(a));
        checkOutput("busy",      32'(busy),      32'(k != 0));
        checkOutput("ctrl_done", 32'(ctrl_done), 32'(k == K_END));
        if ((ctrl_done === 1'b1) && (doneLabel < 0)) doneLabel = label;
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic r);
        @(negedge HCLK);
        checkCycle();
        start    = s;
        abort    = a;
        rd_ready = r;
        if ((rd_en === 1'b1) && r) frameAccepts = frameAccepts + 1;
        @(posedge HCLK);
        modelStep(s, a, r);
        label = label + 1;
    endtask

    task automatic beginScenario();
        label        = 0;
        doneLabel    = -1;
        frameAccepts = 0;
    endtask

    task automatic plainFrame(input string tag);
        beginScenario();
        for (int i = 0; i < 20; i++) applyStimulus(i == 0, 1'b0, 1'b1);
        checkOutput({tag, "_doneEdge"}, doneLabel, 16);
        checkOutput({tag, "_accepts"}, frameAccepts, W * H);
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        lastAddr = 0;
        label    = 0;
        HRESET   = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        rd_ready = 1'b0;
        #12;
        checkCycle();
        @(negedge HCLK);
        HRESET = 1'b0;

        // Basic frame with rd_ready held high.
        plainFrame("basic");

        // Three stalled cycles while address 2 is presented.
        beginScenario();
        for (int i = 0; i < 24; i++) applyStimulus(i == 0, 1'b0, !(i >= 8 && i <= 10));
        checkOutput("stall_doneEdge", doneLabel, 19);
        checkOutput("stall_accepts", frameAccepts, W * H);

        // Start re-pulsed while busy and during the DONE cycle.
        beginScenario();
        for (int i = 0; i < 20; i++) applyStimulus((i == 0) || (i == 5) || (i == 16), 1'b0, 1'b1);
        checkOutput("restart_doneEdge", doneLabel, 16);
        checkOutput("restart_accepts", frameAccepts, W * H);

        // Abort in the middle of the first line.
        beginScenario();
        for (int i = 0; i < 14; i++) applyStimulus(i == 0, i == 8, 1'b1);
        checkOutput("abort_noDone", doneLabel, -1);
        plainFrame("afterAbort");

        // Asynchronous reset while addresses are streaming.
        beginScenario();
        for (int i = 0; i < 9; i++) applyStimulus(i == 0, 1'b0, 1'b1);
        start = 1'b0;
        abort = 1'b0;
        #2 HRESET = 1'b1;
        #1;
        checkOutput("rst_VSYNC",     32'(VSYNC),     0);
        checkOutput("rst_HSYNC",     32'(HSYNC),     0);
        checkOutput("rst_rd_en",     32'(rd_en),     0);
        checkOutput("rst_rd_addr",   32'(rd_addr),   0);
        checkOutput("rst_busy",      32'(busy),      0);
        checkOutput("rst_ctrl_done", 32'(ctrl_done), 0);
        checkOutput("rst_noDone", doneLabel, -1);
        model.delete();
        lastAddr = 0;
        @(negedge HCLK);
        HRESET = 1'b0;
        plainFrame("afterReset");

        // Randomized start, abort and back-pressure.
        beginScenario();
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7);
        end
        for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("random_idle", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/image_read_ctrl.md
IMAGE_READ_CTRL -- requirements
Module: image_read_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 768, meaning pixels per line.
REQ-002 The block SHALL have parameter HEIGHT, default 512, meaning lines per frame.
REQ-003 The block SHALL have parameter VSYNC_DELAY, default 100, meaning frame-start blanking in cycles (at least 1).
REQ-004 The block SHALL have parameter HSYNC_DELAY, default 160, meaning line-start blanking in cycles (at least 1).
REQ-005 The block SHALL have localparam ADDR_W = clog2(WIDTH*HEIGHT).
REQ-006 Port HCLK, input, 1, is the single clock; all logic SHALL be rising-edge.
REQ-007 Port HRESET, input, 1, is the reset; it SHALL be asynchronous and active-high.
REQ-008 Port start, input, 1, requests a frame readout.
REQ-009 Port abort, input, 1, terminates the current frame.
REQ-010 Port rd_ready, input, 1, means the pixel memory/consumer accepts the current address.
REQ-011 Port VSYNC, output, 1, is the frame-blanking strobe.
REQ-012 Port HSYNC, output, 1, is the line-active strobe.
REQ-013 Port rd_en, output, 1, marks a valid read address.
REQ-014 Port rd_addr, output, ADDR_W, is the linear pixel address.
REQ-015 Port busy, output, 1, is high in any state except IDLE.
REQ-016 Port ctrl_done, output, 1, is a one-cycle end-of-frame pulse.

Function
REQ-017 The FSM SHALL have states IDLE, VBLANK, HBLANK, DATA and DONE; all outputs SHALL be registered/decoded from state, with no combinational input-to-output path.
REQ-018 IDLE: if start=1 at an edge, the FSM SHALL move to VBLANK and load the delay counter with VSYNC_DELAY.
REQ-019 VBLANK: VSYNC SHALL be 1 for exactly VSYNC_DELAY cycles, then the FSM SHALL move to HBLANK with the row set to 0.
REQ-020 HBLANK: HSYNC SHALL be 0 for exactly HSYNC_DELAY cycles, then the FSM SHALL move to DATA with the column set to 0.
REQ-021 DATA: HSYNC and rd_en SHALL be 1, and rd_addr SHALL equal row*WIDTH+col, produced by an incrementing counter with no multiplier.
REQ-022 A pixel SHALL be accepted when rd_en and rd_ready are both 1; on acceptance col SHALL increment, and when rd_ready=0 rd_addr SHALL hold.
REQ-023 On acceptance of col=WIDTH-1: if row<HEIGHT-1, the FSM SHALL move to HBLANK with row+1; otherwise it SHALL move to DONE.
REQ-024 DONE: ctrl_done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-025 start SHALL be ignored while busy=1; start asserted in the DONE cycle SHALL be ignored.
REQ-026 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with no ctrl_done pulse and counters cleared; abort SHALL have priority over all other transitions.
REQ-027 Outside DATA, rd_en SHALL be 0 and rd_addr SHALL be held at its last value.
REQ-028 Outside VBLANK, VSYNC SHALL be 0.
REQ-029 Each frame SHALL yield exactly WIDTH*HEIGHT accepted addresses, 0 to WIDTH*HEIGHT-1, in order, with no wrap within a frame.

Reset
REQ-030 While HRESET=1, state SHALL be IDLE, VSYNC=0, HSYNC=0, rd_en=0, rd_addr=0, busy=0, ctrl_done=0, and all counters SHALL be 0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame immediately, with no ctrl_done; the first start after release SHALL begin at address 0.

Structure
REQ-032 The state encoding and the clog2 function SHALL reside in the shared package image_pkg.
REQ-033 The blanking delay SHALL be one sub-module, image_delay_cnt (loadable down-counter with a zero flag), instantiated once and reused for VBLANK and HBLANK.

Verification
All scenarios use WIDTH=4, HEIGHT=2, VSYNC_DELAY=3, HSYNC_DELAY=2.
REQ-034 Start pulse at edge 0 with rd_ready=1 -> VSYNC high at edges 1-3, HBLANK at 4-5, addresses 0-3 at 6-9, HBLANK at 10-11, addresses 4-7 at 12-15, ctrl_done at 16, busy low at 17.
REQ-035 rd_ready=0 for 3 cycles while addr=2 -> addr 2 held for 4 cycles, still 8 addresses total, ctrl_done delayed by 3 cycles.
REQ-036 start re-pulsed at edges 5 and 16 -> no effect; the frame is identical to REQ-034.
REQ-037 abort at edge 8 -> IDLE at edge 9, rd_en=0, no ctrl_done; the next start restarts at addr 0.
REQ-038 HRESET asserted asynchronously mid-DATA -> all outputs at reset values before the next edge; after release and a new start, the frame matches REQ-034.
